dsp_mac_unit: RTL and testbench
===============================

# dsp_mac_unit

Iterative 32×32 multiply-accumulate engine for the DSP extension. It consumes the three DSP registers exported by the register file: r16 and r17 are operands, r18 is control. Each run yields a 64-bit product, added to or replacing an internal accumulator. The result goes back to the register file through the core's shared write port via a req/ack handshake.

## Interface
- WIDTH, 32: operand width; r16/r17/wb_data width.
- ACC_WIDTH, 64: accumulator width, fixed at 2×WIDTH.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- r16  input  32  multiplicand.
- r17  input  32  multiplier.
- r18  input  32  control:
  - [0] start
  - [1] accumulate (1 = add to acc, 0 = replace)
  - [2] signed
  - [12:8] rd_lo
  - [17:13] rd_hi
- wb_req  output  1  write request to register-file port.
- wb_addr  output  5  write destination.
- wb_data  output  32  write data.
- wb_ack  input  1  core accepted the write this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final write completes.
- acc  output  64  current accumulator value.

## Operation
- Start detect: start_q <= r18[0] every cycle, in all states. A start event is r18[0]=1 with start_q=0 while in IDLE. Start events in other states are ignored.
- On start, capture r16, r17 and r18[17:1]. Later changes to r16/r17/r18 do not affect the run.
- Signed mode:
  - Operands are made magnitudes (two's-complement negate if MSB=1).
  - The unsigned product is negated if the operand signs differ.
  - 0x80000000 magnitude is 2^31 and is handled correctly.
- States:
  - IDLE: on start → MUL, bit counter = 0, product = 0.
  - MUL: 32 cycles of shift-add, one multiplier bit per cycle, LSB first. After counter=31 → ACC.
  - ACC:
    - Apply sign correction.
    - acc <= accumulate ? acc + product : product. Addition wraps mod 2^64.
    - Next state: WB_LO if rd_lo≠0; else WB_HI if rd_hi≠0; else DONE.
  - WB_LO:
    - wb_req=1, wb_addr=rd_lo, wb_data=acc[31:0].
    - On wb_ack: → WB_HI if rd_hi≠0, else → DONE.
  - WB_HI:
    - wb_req=1, wb_addr=rd_hi, wb_data=acc[63:32].
    - On wb_ack → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- Handshake:
  - While wb_req=1, wb_addr and wb_data stay stable until the cycle wb_ack is sampled high.
  - wb_ack when wb_req=0 is ignored.
  - The write completes on the edge where wb_req=wb_ack=1.
- rd_lo = rd_hi (both nonzero): both writes are issued in order, so the hi word is the final value.
- The accumulator persists across runs and is cleared only by reset or a run with accumulate=0.

## Timing
- Reset (async, immediate): state=IDLE, start_q=0, acc=0, wb_req=0, wb_addr=0, wb_data=0, busy=0, done=0.
- A reset assertion mid-run aborts it. No write completes after reset asserts, and wb_req falls without a clock.
- Start event in cycle T (IDLE): busy=1 from T+1. MUL occupies T+1..T+32, ACC is T+33, WB_LO is entered at T+34.
- wb_ack tied high, both writes enabled: lo written at edge ending T+34, hi at T+35, done=1 in T+36, IDLE at T+37.
- With no writes enabled, done=1 in T+34.
- Each cycle wb_ack stays low adds one cycle of latency.
- Minimum spacing between runs: r18[0] must return to 0 for at least one cycle, then rise again.
- r18[0] held high out of reset triggers a run in the first post-reset cycle, because start_q resets to 0.

## Test plan
- Unsigned 3×5, rd_lo=5, rd_hi=0, wb_ack tied high -> single write r5=0x0000000F, done at T+35, acc=15.
- Signed −7×3, rd_lo=6, rd_hi=7 -> writes r6=0xFFFFFFEB then r7=0xFFFFFFFF, acc=0xFFFFFFFF_FFFFFFEB.
- Accumulate: acc=15, then unsigned 2×4 with accumulate=1, rd_lo=5 -> r5=0x00000017.
- Unsigned 0xFFFFFFFF² with 5 cycles of wb_ack low during WB_LO -> wb_addr/wb_data held for all 5 cycles; lo=0x00000001, hi=0xFFFFFFFE, done 5 cycles late.
- Start toggled during MUL -> ignored, single run, result unchanged.
- Reset in MUL cycle 10 -> outputs return to reset values immediately and no write occurs. A fresh start afterwards runs normally.

Source files
------------

// File: rtl/dsp_mac_unit_if.sv
// Register-file write port shared with the core: the MAC raises wb_req with a
// stable address/data pair until the core answers with wb_ack.
interface dsp_mac_unit_if #(
    parameter int WIDTH = 32
);
    logic             wb_req;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             wb_ack;

    modport master (output wb_req, output wb_addr, output wb_data, input wb_ack);
    modport slave  (input wb_req, input wb_addr, input wb_data, output wb_ack);
endinterface

// File: rtl/dsp_mac_unit.sv
// Iterative 32x32 multiply-accumulate engine. Operands are latched on a start
// edge of r18[0], multiplied one bit per cycle (shift-add on magnitudes), sign
// corrected, folded into a persistent accumulator, then written back as up to
// two words through the register-file write port.
module dsp_mac_unit #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     r16,
    input  logic [WIDTH-1:0]     r17,
    input  logic [WIDTH-1:0]     r18,
    dsp_mac_unit_if.master       wb,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] acc
);

    typedef enum logic [2:0] {IDLE, MUL, ACC, WB_LO, WB_HI, DONE} state_t;

    state_t               state, state_nxt;
    logic                 start_q;
    logic                 start_evt;
    logic [4:0]           cnt;
    logic [ACC_WIDTH-1:0] mcand;
    logic [WIDTH-1:0]     mplier;
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] prod_fix;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 accum_q;
    logic                 neg_q;
    logic [4:0]           rd_lo_q;
    logic [4:0]           rd_hi_q;
    logic                 unused_ctl;

    // Reserved control bits carry no function.
    assign unused_ctl = ^{r18[WIDTH-1:18], r18[7:3]};

    // Magnitude of an operand; 0x80000000 maps to itself, which read unsigned is 2^31.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign start_evt = r18[0] && !start_q && (state == IDLE);
    assign prod_fix  = neg_q ? -prod : prod;
    assign acc       = acc_q;

    // Edge detector on the start bit runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= r18[0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and write-port outputs; port outputs read zero outside the write states.
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        wb.wb_req  = 1'b0;
        wb.wb_addr = 5'd0;
        wb.wb_data = '0;
        case (state)
            IDLE:  if (start_evt) state_nxt = MUL;
            MUL:   if (cnt == 5'd31) state_nxt = ACC;
            ACC: begin
                if (rd_lo_q != 5'd0)      state_nxt = WB_LO;
                else if (rd_hi_q != 5'd0) state_nxt = WB_HI;
                else                      state_nxt = DONE;
            end
            WB_LO: begin
                wb.wb_req  = 1'b1;
                wb.wb_addr = rd_lo_q;
                wb.wb_data = acc_q[WIDTH-1:0];
                if (wb.wb_ack) state_nxt = (rd_hi_q != 5'd0) ? WB_HI : DONE;
            end
            WB_HI: begin
                wb.wb_req  = 1'b1;
                wb.wb_addr = rd_hi_q;
                wb.wb_data = acc_q[ACC_WIDTH-1:WIDTH];
                if (wb.wb_ack) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add multiply, accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            acc_q   <= '0;
            accum_q <= 1'b0;
            neg_q   <= 1'b0;
            rd_lo_q <= 5'd0;
            rd_hi_q <= 5'd0;
        end else begin
            case (state)
                IDLE: if (start_evt) begin
                    cnt     <= 5'd0;
                    prod    <= '0;
                    mcand   <= {{(ACC_WIDTH-WIDTH){1'b0}}, mag(r16, r18[2])};
                    mplier  <= mag(r17, r18[2]);
                    accum_q <= r18[1];
                    neg_q   <= r18[2] && (r16[WIDTH-1] ^ r17[WIDTH-1]);
                    rd_lo_q <= r18[12:8];
                    rd_hi_q <= r18[17:13];
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                ACC: acc_q <= accum_q ? acc_q + prod_fix : prod_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_unit.sv
// Randomized bench for dsp_mac_unit: each run is predicted with plain 64-bit
// arithmetic (sign-extend and multiply) and the write sequence, data hold
// under stalls, done timing and accumulator are compared against it.
module tb_dsp_mac_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] r16 = '0, r17 = '0, r18 = '0;
    logic        busy, done;
    logic [63:0] acc;
    int          checks = 0, failures = 0;
    int          stall = 0;
    logic [63:0] acc_m = '0;

    dsp_mac_unit_if #(.WIDTH(32)) wb_bus ();

    dsp_mac_unit dut (
        .clk(clk), .rst_n(rst_n), .r16(r16), .r17(r17), .r18(r18),
        .wb(wb_bus), .busy(busy), .done(done), .acc(acc)
    );

    always #5 clk = ~clk;

    // Core side of the write port: ack high unless a stall budget is pending on a live request.
    initial wb_bus.wb_ack = 1'b1;
    always @(posedge clk) begin
        #1;
        if (stall > 0 && wb_bus.wb_req) begin
            wb_bus.wb_ack = 1'b0;
            stall--;
        end else begin
            wb_bus.wb_ack = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit accum,
                       input bit sgn, input logic [4:0] lo, input logic [4:0] hi,
                       input int stl, input bit tog);
        logic [63:0] p;
        int          nw, exp_done, n, wr;
        bit          got;
        p     = sgn ? ({{32{a[31]}}, a} * {{32{b[31]}}, b}) : ({32'd0, a} * {32'd0, b});
        acc_m = accum ? acc_m + p : p;
        nw    = int'(lo != 5'd0) + int'(hi != 5'd0);
        exp_done = 34 + nw + ((nw > 0) ? stl : 0);

        @(posedge clk); #1;
        stall = stl;
        r16 = a; r17 = b;
        r18 = {14'd0, hi, lo, 5'd0, sgn, accum, 1'b1};
        @(negedge clk);
        chk("busy_at_start", busy, 0);
        n = 0; wr = 0; got = 0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                r18[0] = 1'b0;
                r16 = $urandom; r17 = $urandom;
            end
            if (tog && (n == 5 || n == 20)) r18 = $urandom | 32'd1;
            if (tog && (n == 6 || n == 21)) r18[0] = 1'b0;
            @(negedge clk);
            if (n == 1) chk("busy_t1", busy, 1);
            if (wb_bus.wb_req) begin
                if (wr == 0 && lo != 5'd0) begin
                    chk("wb_addr_lo", wb_bus.wb_addr, lo);
                    chk("wb_data_lo", wb_bus.wb_data, acc_m[31:0]);
                end else begin
                    chk("wb_addr_hi", wb_bus.wb_addr, hi);
                    chk("wb_data_hi", wb_bus.wb_data, acc_m[63:32]);
                end
                if (wb_bus.wb_ack) wr++;
            end
            if (done) got = 1;
        end
        chk("done_cycle", n, exp_done);
        chk("write_count", wr, nw);
        chk("acc", acc, acc_m);
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_req", wb_bus.wb_req, 0);
        chk("rst_wb_addr", wb_bus.wb_addr, 0);
        chk("rst_wb_data", wb_bus.wb_data, 0);
        chk("rst_acc", acc, 0);
        rst_n = 1'b1;

        run(32'd3, 32'd5, 0, 0, 5'd5, 5'd0, 0, 0);
        run(32'd2, 32'd4, 1, 0, 5'd5, 5'd0, 0, 0);
        run(-32'sd7, 32'd3, 0, 1, 5'd6, 5'd7, 0, 0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd1, 5'd2, 5, 0);
        run(32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 5'd3, 5'd4, 0, 1);
        run(32'h8000_0000, 32'h8000_0000, 0, 1, 5'd8, 5'd9, 0, 0);
        run(32'h8000_0000, 32'd1, 1, 1, 5'd10, 5'd10, 2, 0);
        run(32'd9, 32'd9, 1, 0, 5'd0, 5'd0, 0, 0);
        run(32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1, 5'd0, 5'd11, 1, 0);
        for (int i = 0; i < 20; i++)
            run($urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom),
                5'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

        // Abort in the middle of the multiply.
        @(posedge clk); #1;
        r16 = 32'd100; r17 = 32'd200;
        r18 = {14'd0, 5'd12, 5'd13, 5'd0, 3'b001};
        repeat (11) @(posedge clk);
        #1 r18[0] = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        acc_m = '0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wb_req", wb_bus.wb_req, 0);
        chk("abort_wb_addr", wb_bus.wb_addr, 0);
        chk("abort_wb_data", wb_bus.wb_data, 0);
        chk("abort_acc", acc, 0);
        repeat (3) @(negedge clk);
        chk("abort_hold_req", wb_bus.wb_req, 0);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (wb_bus.wb_req || busy) chk("no_write_after_abort", {wb_bus.wb_req, busy}, 2'b00);
        end
        run(32'd6, 32'd7, 1, 0, 5'd14, 5'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
